// File: rtl/weight_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : weight_load_ctrl
// Purpose  : Streams a WEIGHT_ROWS x WEIGHT_COLS weight tile from the weight
//            SRAM into the systolic array weight registers. It issues reads in
//            row-major order and absorbs the one-cycle SRAM read latency in a
//            two-entry output buffer. Each word is presented on a valid/ready
//            stream, tagged with its row and column.
// Ports    : clk, reset (async, active-high)
//            start, base_addr             - tile load request
//            mem_rd_en, mem_addr,
//            mem_rd_data                  - SRAM read port (1-cycle latency)
//            w_valid, w_ready, w_data,
//            w_row, w_col                 - weight word stream
//            Weight_Enable, CountIn       - accept strobe and column count
//                                           for the downstream column counter
//            busy, done                   - load status
// Revision : 1.0 - initial release
// ============================================================================
module weight_load_ctrl #(
   parameter int WEIGHT_ROWS = 3,
   parameter int WEIGHT_COLS = 3,
   parameter int DATA_WIDTH  = 8,
   parameter int ADDR_WIDTH  = 10,
   parameter int ROW_WIDTH   = (WEIGHT_ROWS > 1) ? $clog2(WEIGHT_ROWS) : 1,
   parameter int COL_WIDTH   = (WEIGHT_COLS > 1) ? $clog2(WEIGHT_COLS) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   output logic                  mem_rd_en,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_rd_data,
   output logic                  w_valid,
   input  logic                  w_ready,
   output logic [DATA_WIDTH-1:0] w_data,
   output logic [ROW_WIDTH-1:0]  w_row,
   output logic [COL_WIDTH-1:0]  w_col,
   output logic                  Weight_Enable,
   output logic [COL_WIDTH-1:0]  CountIn,
   output logic                  busy,
   output logic                  done
);

   localparam logic [ROW_WIDTH-1:0] c_LAST_ROW = ROW_WIDTH'(WEIGHT_ROWS - 1);
   localparam logic [COL_WIDTH-1:0] c_LAST_COL = COL_WIDTH'(WEIGHT_COLS - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_addr;       // next read address (wraps naturally)
   logic [ROW_WIDTH-1:0]  r_row;        // next read row
   logic [COL_WIDTH-1:0]  r_col;        // next read column
   logic                  r_inflight;   // read issued last cycle, data arrives now
   logic [ROW_WIDTH-1:0]  r_req_row;    // tag of the in-flight read
   logic [COL_WIDTH-1:0]  r_req_col;

   // Two-entry FIFO holding returned words with their tags
   logic [DATA_WIDTH-1:0] r_buf_data [2];
   logic [ROW_WIDTH-1:0]  r_buf_row  [2];
   logic [COL_WIDTH-1:0]  r_buf_col  [2];
   logic                  r_rd_ptr;
   logic                  r_wr_ptr;
   logic [1:0]            r_occ;

   logic                  w_pop;
   logic                  w_push;
   logic [2:0]            w_level;
   logic                  w_issue;
   logic                  w_last_issue;
   logic                  w_head_last;

   assign w_pop  = (r_occ != 2'd0) && w_ready;
   assign w_push = r_inflight;

   // Slots that will still be committed after this cycle's pop; a new read
   // is only allowed when one slot remains free for its returning data.
   assign w_level      = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
   assign w_issue      = (r_state == S_LOAD) && (w_level < 3'd2);
   assign w_last_issue = w_issue && (r_row == c_LAST_ROW) && (r_col == c_LAST_COL);
   assign w_head_last  = (r_buf_row[r_rd_ptr] == c_LAST_ROW) &&
                         (r_buf_col[r_rd_ptr] == c_LAST_COL);

   assign mem_rd_en     = w_issue;
   assign mem_addr      = r_addr;
   assign w_valid       = (r_occ != 2'd0);
   assign w_data        = r_buf_data[r_rd_ptr];
   assign w_row         = r_buf_row[r_rd_ptr];
   assign w_col         = r_buf_col[r_rd_ptr];
   assign Weight_Enable = w_pop;
   assign CountIn       = r_buf_col[r_rd_ptr];
   assign busy          = (r_state != S_IDLE);
   assign done          = (r_state == S_DONE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_addr     <= '0;
         r_row      <= '0;
         r_col      <= '0;
         r_inflight <= 1'b0;
         r_req_row  <= '0;
         r_req_col  <= '0;
         r_rd_ptr   <= 1'b0;
         r_wr_ptr   <= 1'b0;
         r_occ      <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            r_buf_data[i] <= '0;
            r_buf_row[i]  <= '0;
            r_buf_col[i]  <= '0;
         end
      end else begin
         r_inflight <= w_issue;

         if (w_issue) begin
            r_req_row <= r_row;
            r_req_col <= r_col;
            r_addr    <= r_addr + ADDR_WIDTH'(1);
            if (r_col == c_LAST_COL) begin
               r_col <= '0;
               r_row <= r_row + ROW_WIDTH'(1);
            end else begin
               r_col <= r_col + COL_WIDTH'(1);
            end
         end

         // Returning SRAM data lands in the buffer with its request tag
         if (w_push) begin
            r_buf_data[r_wr_ptr] <= mem_rd_data;
            r_buf_row[r_wr_ptr]  <= r_req_row;
            r_buf_col[r_wr_ptr]  <= r_req_col;
            r_wr_ptr             <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};

         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state <= S_LOAD;
                  r_addr  <= base_addr;
                  r_row   <= '0;
                  r_col   <= '0;
               end
            end
            S_LOAD: begin
               if (w_last_issue) begin
                  r_state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (w_pop && w_head_last) begin
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
